// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Command-driven controller for a shared combinational 32-bit ALU
//   (ops 0-7: zero/add/sub/shl1/shr1/and/or/xor). It accepts one command per
//   valid/ready handshake, drives the ALU select/operand lines, captures the
//   ALU output and returns it through a second valid/ready handshake. Op 8 is
//   a fixed-latency shift-add multiply that reuses the ALU adder once per
//   iteration. Ops 9-15 return an error response.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b         opcode and operands
//   alu_a, alu_b, alu_s          registered drive to the ALU
//   alu_o                        combinational ALU result
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_err            result, illegal-opcode flag
//   busy                         high whenever not IDLE
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WIDTH     = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  input  logic [WIDTH-1:0] alu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int ITW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_s;
  logic [WIDTH-1:0] r_m;       // multiplicand for the next iteration
  logic [WIDTH-1:0] r_q;       // multiplier bits still to consume
  logic [ITW-1:0]   r_iter;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic             w_accept;
  logic             w_rsp_hs;
  logic             w_mul_last;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;
  assign w_mul_last = (r_iter == ITW'(MUL_ITERS - 1));

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_op <= 4'd7)      w_next = S_EXEC;
          else if (cmd_op == 4'd8) w_next = S_MUL;
          else                     w_next = S_DONE;
        end
      end
      S_EXEC:  w_next = S_DONE;
      S_MUL:   if (w_mul_last) w_next = S_DONE;
      S_DONE:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The ALU drive registers double as the operand latches: they are loaded on
  // the accepting edge so the ALU sees the operation in the very next cycle.
  // During MUL, alu_a holds the running partial product P and alu_b holds the
  // addend (M or 0) selected by the current multiplier bit.
  // NOTE: every register here is a plain flop (no arrays), so all of them are
  // cleared by the async reset; a command in flight is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_iter      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cmd_op <= 4'd7) begin
              r_alu_a <= cmd_a;
              r_alu_b <= cmd_b;
              r_alu_s <= cmd_op;
            end else if (cmd_op == 4'd8) begin
              r_alu_a <= '0;
              r_alu_b <= cmd_b[0] ? cmd_a : '0;
              r_alu_s <= 4'd1;
              r_m     <= cmd_a << 1;
              r_q     <= cmd_b >> 1;
              r_iter  <= '0;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= alu_o;
          r_rsp_err   <= 1'b0;
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_s     <= '0;
        end
        S_MUL: begin
          if (w_mul_last) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= alu_o;
            r_rsp_err   <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= '0;
          end else begin
            r_alu_a <= alu_o;
            r_alu_b <= r_q[0] ? r_m : '0;
            r_m     <= r_m << 1;
            r_q     <= r_q >> 1;
            r_iter  <= r_iter + 1'b1;
          end
        end
        S_DONE: begin
          if (w_rsp_hs) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a behavioural model of the shared
//   combinational ALU. Inputs change 1 ns after the rising edge and outputs are
//   sampled there as well, away from the active edge.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_s;
  logic [WIDTH-1:0] alu_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.WIDTH(WIDTH), .MUL_ITERS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_o     (alu_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Shared ALU model.
  always_comb begin
    alu_o = '0;
    case (alu_s)
      4'd1:    alu_o = alu_a + alu_b;
      4'd2:    alu_o = alu_a - alu_b;
      4'd3:    alu_o = alu_a << 1;
      4'd4:    alu_o = alu_a >> 1;
      4'd5:    alu_o = alu_a & alu_b;
      4'd6:    alu_o = alu_a | alu_b;
      4'd7:    alu_o = alu_a ^ alu_b;
      default: alu_o = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command; returns 1 ns after the accepting edge (cycle T+1).
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = '0;
    cmd_b     = '0;
  endtask

  // Counts edges after the accepting edge until rsp_valid shows.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, rsp_valid, 0);
    check({tag, "_idle_after"}, cmd_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int exp_lat, input logic [WIDTH-1:0] exp_data,
                        input logic exp_err);
    send(op, a, b);
    wait_rsp(tag, exp_lat);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_alu_idle"}, alu_s, 0);
    consume(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;

    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_busy",      busy, 0);
    check("rst_alu_a",     alu_a, 0);
    check("rst_alu_b",     alu_b, 0);
    check("rst_alu_s",     alu_s, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rst_cmd_ready", cmd_ready, 1);

    // add, with the EXEC-cycle ALU drive inspected directly
    send(4'd1, 32'h0000_0005, 32'h0000_0003);
    check("add_exec_busy",  busy, 1);
    check("add_exec_ready", cmd_ready, 0);
    check("add_exec_alu_s", alu_s, 1);
    check("add_exec_alu_a", alu_a, 32'h0000_0005);
    check("add_exec_alu_b", alu_b, 32'h0000_0003);
    wait_rsp("add", 1);
    check("add_data", rsp_data, 32'h0000_0008);
    check("add_err",  rsp_err, 0);
    consume("add");

    run_op("sub_wrap", 4'd2, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("shl1",     4'd3, 32'h8000_0001, 32'h0000_0000, 1, 32'h0000_0002, 1'b0);
    run_op("shr1",     4'd4, 32'h8000_0001, 32'h0000_0000, 1, 32'h4000_0000, 1'b0);
    run_op("or",       4'd6, 32'h1200_0034, 32'h0056_7800, 1, 32'h1256_7834, 1'b0);
    run_op("xor",      4'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F, 1'b0);

    // MUL: first iteration drives P=0 and Q[0]=0 selects a zero addend
    send(4'd8, 32'h0000_1234, 32'h0000_0010);
    check("mul_iter0_alu_s", alu_s, 1);
    check("mul_iter0_alu_a", alu_a, 0);
    check("mul_iter0_alu_b", alu_b, 0);
    wait_rsp("mul", 32);
    check("mul_data", rsp_data, 32'h0001_2340);
    check("mul_err",  rsp_err, 0);
    consume("mul");

    run_op("mul_ones",  4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001, 1'b0);
    run_op("mul_small", 4'd8, 32'h0000_0003, 32'h0000_0005, 32, 32'h0000_000F, 1'b0);

    // backpressure: result held while a stray command is presented
    send(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_rsp("and", 1);
    cmd_valid = 1'b1;
    cmd_op    = 4'd1;
    cmd_a     = 32'h1111_1111;
    cmd_b     = 32'h2222_2222;
    for (int i = 0; i < 10; i++) begin
      step();
      check("and_hold_data",  rsp_data, 32'hF000_F000);
      check("and_hold_valid", rsp_valid, 1);
      check("and_hold_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    check("and_err", rsp_err, 0);
    consume("and");

    // illegal opcode, then op 0 clears the error flag
    run_op("illegal", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h0000_0000, 1'b1);
    run_op("zero_op", 4'd0,  32'h0000_0005, 32'h0000_0003, 1, 32'h0000_0000, 1'b0);

    // reset during MUL at cycle T+10
    send(4'd8, 32'h0000_1234, 32'h0000_0010);
    repeat (9) step();
    check("mid_mul_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data",  rsp_data, 0);
    check("midrst_busy",      busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_alu_a",     alu_a, 0);
    check("midrst_alu_s",     alu_s, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    begin
      logic saw_rsp = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (rsp_valid) saw_rsp = 1'b1;
      end
      check("midrst_no_rsp", saw_rsp, 0);
    end
    check("midrst_ready_after", cmd_ready, 1);
    run_op("recover_add", 4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
